// File: rtl/fifo_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_access_sched
// Brief    : Arbitrates two byte writers and one reader onto a single-port
//            FIFO, alternating writes and reads whenever both contend.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_access_sched (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] din0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] din1,
    output logic       gnt1,
    input  logic       rd_req,
    output logic       rd_gnt,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       fifo_wn,
    output logic       fifo_rn,
    output logic [7:0] fifo_din,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic [3:0] level
);

    localparam logic [3:0] C_LEVEL_MAX = 4'd8;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_t;

    op_t        r_last_op;
    op_t        w_last_op_nxt;
    logic       r_rr;
    logic       w_rr_nxt;
    logic [3:0] r_level;
    logic [3:0] w_level_nxt;
    logic       r_rd_valid;

    logic       w_wr_elig;
    logic       w_rd_elig;
    logic       w_do_wr;
    logic       w_do_rd;
    logic       w_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_op  <= OP_NONE;
            r_rr       <= 1'b0;
            r_level    <= 4'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_last_op  <= w_last_op_nxt;
            r_rr       <= w_rr_nxt;
            r_level    <= w_level_nxt;
            r_rd_valid <= w_do_rd;
        end
    end

    always_comb begin
        w_last_op_nxt = r_last_op;
        w_rr_nxt      = r_rr;
        w_level_nxt   = r_level;
        w_do_wr       = 1'b0;
        w_do_rd       = 1'b0;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        rd_gnt        = 1'b0;
        fifo_wn       = 1'b0;
        fifo_rn       = 1'b0;
        fifo_din      = 8'h00;

        // Eligibility is masked by reset so every issue output reads 0 while reset is held.
        w_wr_elig = (req0 | req1) & ~fifo_full & ~reset;
        w_rd_elig = rd_req & ~fifo_empty & ~reset;
        w_sel     = (req0 & req1) ? r_rr : req1;

        if (w_wr_elig && w_rd_elig) begin
            if (r_last_op == OP_WR) begin
                w_do_rd = 1'b1;
            end else begin
                w_do_wr = 1'b1;
            end
        end else if (w_wr_elig) begin
            w_do_wr = 1'b1;
        end else if (w_rd_elig) begin
            w_do_rd = 1'b1;
        end

        if (w_do_wr) begin
            fifo_wn       = 1'b1;
            gnt0          = ~w_sel;
            gnt1          = w_sel;
            fifo_din      = w_sel ? din1 : din0;
            w_rr_nxt      = ~w_sel;
            w_last_op_nxt = OP_WR;
            if (r_level != C_LEVEL_MAX) begin
                w_level_nxt = r_level + 4'd1;
            end
        end

        if (w_do_rd) begin
            fifo_rn       = 1'b1;
            rd_gnt        = 1'b1;
            w_last_op_nxt = OP_RD;
            if (r_level != 4'd0) begin
                w_level_nxt = r_level - 4'd1;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = fifo_dout;
    assign level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_access_sched
// Brief    : Directed self-checking bench for fifo_access_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_access_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1, rd_req;
    logic [7:0] din0, din1;
    logic       gnt0, gnt1, rd_gnt, rd_valid;
    logic [7:0] rd_data;
    logic       fifo_wn, fifo_rn;
    logic [7:0] fifo_din;
    logic [7:0] fifo_dout;
    logic       fifo_full, fifo_empty;
    logic [3:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    // {fifo_wn, fifo_rn, gnt0, gnt1, rd_gnt, fifo_din}
    logic [12:0] comb;
    logic [12:0] exp;
    assign comb = {fifo_wn, fifo_rn, gnt0, gnt1, rd_gnt, fifo_din};

    fifo_access_sched dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .din0       (din0),
        .gnt0       (gnt0),
        .req1       (req1),
        .din1       (din1),
        .gnt1       (gnt1),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_wn    (fifo_wn),
        .fifo_rn    (fifo_rn),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        din0 = 8'h00; din1 = 8'h00;
        fifo_full = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1;
        din0 = 8'h11; din1 = 8'h22;
        fifo_full = 1'b0; fifo_empty = 1'b0; fifo_dout = 8'h00;
        #1;
        n_cmp++;
        if (comb !== 13'd0) begin
            n_bad++; $display("FAIL reset_comb: got %h want %h", comb, 13'd0);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (level !== 4'd0 || rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs: level=%0d rd_valid=%b want 0/0", level, rd_valid);
        end
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (comb !== 13'd0 || level !== 4'd0 || rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: comb=%h level=%0d rd_valid=%b want 0", comb, level, rd_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_din [3];
        exp_din[0] = 8'hA0; exp_din[1] = 8'hB1; exp_din[2] = 8'hA0;
        @(negedge clock);
        req0 = 1'b1; req1 = 1'b1; din0 = 8'hA0; din1 = 8'hB1; fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = {1'b1, 1'b0, (i != 1), (i == 1), 1'b0, exp_din[i]};
            n_cmp++;
            if (comb !== exp) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %h want %h", i, comb, exp);
            end
            @(posedge clock); #1;
            n_cmp++;
            if (level !== 4'(i + 1)) begin
                n_bad++; $display("FAIL rr_level[%0d]: got %0d want %0d", i, level, i + 1);
            end
            @(negedge clock);
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        n_cmp++;
        if (comb !== 13'd0) begin
            n_bad++; $display("FAIL rr_idle: got %h want %h", comb, 13'd0);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        @(negedge clock);
        req0 = 1'b1; fifo_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din0 = 8'h30 + 8'(i);
            #1;
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30 + 8'(i)};
            n_cmp++;
            if (comb !== exp) begin
                n_bad++; $display("FAIL fill_write[%0d]: got %h want %h", i, comb, exp);
            end
            @(negedge clock);
        end
        req0 = 1'b0; rd_req = 1'b1; fifo_empty = 1'b0;
        #1;
        n_cmp++;
        if (comb !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}) begin
            n_bad++; $display("FAIL drain_read: got %h want %h", comb, {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
        end
        @(posedge clock); #1;
        n_cmp++;
        if (level !== 4'd3) begin
            n_bad++; $display("FAIL drain_level: got %0d want 3", level);
        end
        @(negedge clock);
        req0 = 1'b1; din0 = 8'h40; rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = (i % 2 == 0) ? {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40}
                               : {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
            n_cmp++;
            if (comb !== exp) begin
                n_bad++; $display("FAIL alt_op[%0d]: got %h want %h", i, comb, exp);
            end
            @(posedge clock); #1;
            n_cmp++;
            if (level !== ((i % 2 == 0) ? 4'd4 : 4'd3) || rd_valid !== (i % 2 == 1)) begin
                n_bad++; $display("FAIL alt_state[%0d]: level=%0d rd_valid=%b want %0d/%b",
                                  i, level, rd_valid, (i % 2 == 0) ? 4 : 3, (i % 2 == 1));
            end
            @(negedge clock);
        end
        req0 = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_full();
        fifo_full = 1'b1; req1 = 1'b1; din1 = 8'h77; fifo_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (comb !== 13'd0) begin
                n_bad++; $display("FAIL full_hold[%0d]: got %h want %h", i, comb, 13'd0);
            end
            @(negedge clock);
        end
        fifo_full = 1'b0;
        #1;
        n_cmp++;
        if (comb !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77}) begin
            n_bad++; $display("FAIL full_release: got %h want %h", comb, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77});
        end
        @(posedge clock); #1;
        n_cmp++;
        if (level !== 4'd4) begin
            n_bad++; $display("FAIL full_level: got %0d want 4", level);
        end
        @(negedge clock);
        req1 = 1'b0;
    endtask

    task automatic test_read_data();
        do_reset();
        @(negedge clock);
        req0 = 1'b1; din0 = 8'h5C; fifo_empty = 1'b1;
        #1;
        n_cmp++;
        if (comb !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5C}) begin
            n_bad++; $display("FAIL rd_write: got %h want %h", comb, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5C});
        end
        @(negedge clock);
        req0 = 1'b0; fifo_empty = 1'b0; rd_req = 1'b1;
        #1;
        n_cmp++;
        if (rd_gnt !== 1'b1 || fifo_rn !== 1'b1 || rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_issue: rd_gnt=%b fifo_rn=%b rd_valid=%b want 1/1/0", rd_gnt, fifo_rn, rd_valid);
        end
        @(posedge clock); #1;
        fifo_dout = 8'h5C;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5C || level !== 4'd0) begin
            n_bad++; $display("FAIL rd_data: valid=%b data=%h level=%0d want 1/5c/0", rd_valid, rd_data, level);
        end
        @(negedge clock);
        rd_req = 1'b0; fifo_empty = 1'b1;
        @(posedge clock); #1;
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid);
        end
    endtask

    task automatic test_reset_async();
        @(negedge clock);
        req0 = 1'b1; din0 = 8'h99; fifo_empty = 1'b1;
        @(negedge clock);
        req0 = 1'b0; rd_req = 1'b1; fifo_empty = 1'b0;
        @(posedge clock); #1;
        n_cmp++;
        if (rd_valid !== 1'b1) begin
            n_bad++; $display("FAIL async_pre: rd_valid=%b want 1", rd_valid);
        end
        #2;
        reset = 1'b1; req0 = 1'b1;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0 || level !== 4'd0 || comb !== 13'd0) begin
            n_bad++; $display("FAIL async_reset: rd_valid=%b level=%0d comb=%h want 0/0/0", rd_valid, level, comb);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (rd_valid !== 1'b0 || comb !== 13'd0) begin
            n_bad++; $display("FAIL async_hold: rd_valid=%b comb=%h want 0/0", rd_valid, comb);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (comb !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99}) begin
            n_bad++; $display("FAIL post_reset_issue: got %h want %h", comb, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99});
        end
        @(posedge clock); #1;
        n_cmp++;
        if (level !== 4'd1) begin
            n_bad++; $display("FAIL post_reset_level: got %0d want 1", level);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_alternate();
        test_full();
        test_read_data();
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_access_sched.md
FIFO_ACCESS_SCHED -- requirements
Module: fifo_access_sched

Interface
Parameters: none.
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock shared with the FIFO.
- reset  in  1  asynchronous active-high reset.
- req0  in  1  writer 0 has a byte pending (level).
- din0  in  8  writer 0 data.
- gnt0  out  1  writer 0 byte accepted this cycle.
- req1  in  1  writer 1 has a byte pending (level).
- din1  in  8  writer 1 data.
- gnt1  out  1  writer 1 byte accepted this cycle.
- rd_req  in  1  consumer requests one byte per cycle (level).
- rd_gnt  out  1  read issued this cycle.
- rd_valid  out  1  rd_data valid (one cycle after rd_gnt).
- rd_data  out  8  read byte, equal to fifo_dout.
- fifo_wn  out  1  FIFO write enable.
- fifo_rn  out  1  FIFO read enable.
- fifo_din  out  8  FIFO write data.
- fifo_dout  in  8  FIFO registered read data.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- level  out  4  count of bytes issued into the FIFO and not yet read, 0..8.

Function
REQ-003 At most one FIFO operation SHALL issue per cycle; fifo_wn and fifo_rn SHALL never be high together.
REQ-004 Write-eligible = (req0 | req1) & !fifo_full; read-eligible = rd_req & !fifo_empty.
REQ-005 fifo_wn, fifo_rn, gnt0, gnt1, rd_gnt and fifo_din SHALL be combinational from current inputs and state, so the FIFO captures on the same rising edge.
REQ-006 The state register last_op SHALL take one of three values: NONE, WR, RD; it updates each cycle to the op issued, or holds when nothing issues.
REQ-007 If only write-eligible, issue a write; if only read-eligible, issue a read.
REQ-008 If both are eligible, issue a read when last_op == WR, otherwise issue a write, so writes and reads alternate under contention.
REQ-009 Writer selection SHALL use a 1-bit round-robin pointer rr (reset 0): if both req0 and req1 are high, grant writer rr; if one is high, grant that writer.
REQ-010 After granting writer k, rr SHALL become 1-k; rr SHALL hold when no write issues.
REQ-011 On a write grant to writer k: gntk = 1, fifo_wn = 1, fifo_din = dink; the other gnt = 0.
REQ-012 When no write issues, fifo_din SHALL be 8'h00.
REQ-013 A requester SHALL treat gnt as consumption of its current byte; it may present the next byte in the following cycle.
REQ-014 On a read: rd_gnt = fifo_rn = 1; rd_valid SHALL be registered high on the next cycle, with rd_data = fifo_dout in that cycle.
REQ-015 Back-to-back reads SHALL produce back-to-back rd_valid.
REQ-016 level SHALL increment by 1 on a write and decrement by 1 on a read; it never does both in one cycle.
REQ-017 level SHALL saturate at 8 and 0; it is informational only and SHALL NOT gate issue (the fifo_full and fifo_empty flags govern).
REQ-018 While fifo_full = 1, gnt0 and gnt1 SHALL stay 0 and pending writes wait; while fifo_empty = 1, rd_gnt SHALL stay 0.

Reset
REQ-019 Asserting reset SHALL immediately set last_op = NONE, rr = 0, level = 0 and rd_valid = 0, regardless of clock.
REQ-020 While reset = 1, all combinational outputs SHALL be 0: fifo_wn, fifo_rn, gnt0, gnt1, rd_gnt and fifo_din.
REQ-021 Reset asserted mid-operation SHALL discard any pending rd_valid; the first issue SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset then idle -> all outputs 0, level = 0.
- req0 = req1 = 1 held, din0 = 8'hA0, din1 = 8'hB1, FIFO empty -> gnt0 then gnt1 then gnt0 on successive cycles; fifo_din = A0, B1, A0; level = 1, 2, 3.
- FIFO holding 3 bytes, req0 = 1 and rd_req = 1 held -> ops alternate W, R, W, R; fifo_wn and fifo_rn never coincide; level oscillates 4, 3, 4, 3.
- fifo_full = 1 with req1 = 1 -> gnt1 = 0 until fifo_full drops; gnt1 = 1 in the first cycle fifo_full = 0.
- Write 8'h5C into empty FIFO, then rd_req pulse -> rd_gnt cycle N, rd_valid = 1 with rd_data = 8'h5C at cycle N+1.
- Assert reset asynchronously in the cycle after rd_gnt -> rd_valid = 0 immediately, level = 0, no grants while reset is high.
